// File: rtl/spi_instruction_receiver.sv
// rtl/spi_instruction_receiver.sv - SPI mode-0 slave receiving opcode/operand frames and returning a result on MISO
// Resynchronises SCLK/CS_N/MOSI into clk; frames are accepted only when exactly FRAME_BITS bits arrive.
module spi_instruction_receiver #(
  parameter int OPCODE_WIDTH  = 4,
  parameter int OPERAND_WIDTH = 8,
  parameter int RESULT_WIDTH  = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_sclk,
  input  logic                     spi_cs_n,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  input  logic [RESULT_WIDTH-1:0]  result,
  output logic [OPCODE_WIDTH-1:0]  opcode,
  output logic [OPERAND_WIDTH-1:0] operand,
  output logic                     start,
  output logic                     frame_err
);

  localparam int FRAME_BITS = OPCODE_WIDTH + OPERAND_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] C_FRAME_BITS = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ISSUE = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0]   r_sclk_sync;
  logic [SYNC_STAGES-1:0]   r_cs_sync;
  logic [SYNC_STAGES-1:0]   r_mosi_sync;
  logic                     r_sclk_prev;
  state_t                   r_state;
  state_t                   w_next;
  logic [CNT_W-1:0]         r_bitcnt;
  logic                     r_overrun;
  logic [FRAME_BITS-1:0]    r_rx_sr;
  logic [RESULT_WIDTH-1:0]  r_tx_sr;
  logic [OPCODE_WIDTH-1:0]  r_opcode;
  logic [OPERAND_WIDTH-1:0] r_operand;
  logic                     r_start;
  logic                     r_frame_err;

  logic w_sclk;
  logic w_cs_n;
  logic w_mosi;
  logic w_sclk_rise;
  logic w_sclk_fall;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;

  // CS_N synchroniser resets to the deselected level so reset never fakes a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_prev <= w_sclk;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_cs_n) begin
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_cs_n) begin
          w_next = ((r_bitcnt == C_FRAME_BITS) && !r_overrun) ? ST_ISSUE : ST_ERROR;
        end
      end
      ST_ISSUE: w_next = ST_IDLE;
      ST_ERROR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitcnt    <= '0;
      r_overrun   <= 1'b0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_opcode    <= '0;
      r_operand   <= '0;
      r_start     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_start     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_cs_n) begin
            r_bitcnt  <= '0;
            r_overrun <= 1'b0;
            r_tx_sr   <= result;
          end
        end
        ST_SHIFT: begin
          // The cycle CS_N is seen high belongs to the frame end, not to the frame.
          if (!w_cs_n) begin
            if (w_sclk_rise) begin
              if (r_bitcnt < C_FRAME_BITS) begin
                r_rx_sr  <= {r_rx_sr[FRAME_BITS-2:0], w_mosi};
                r_bitcnt <= r_bitcnt + CNT_W'(1);
              end else begin
                r_overrun <= 1'b1;
              end
            end
            if (w_sclk_fall) begin
              r_tx_sr <= {r_tx_sr[RESULT_WIDTH-2:0], 1'b0};
            end
          end
        end
        ST_ISSUE: begin
          r_opcode  <= r_rx_sr[FRAME_BITS-1 -: OPCODE_WIDTH];
          r_operand <= r_rx_sr[OPERAND_WIDTH-1:0];
          r_start   <= 1'b1;
        end
        ST_ERROR: begin
          r_frame_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign spi_miso  = ~w_cs_n & r_tx_sr[RESULT_WIDTH-1];
  assign opcode    = r_opcode;
  assign operand   = r_operand;
  assign start     = r_start;
  assign frame_err = r_frame_err;

endmodule
